// File: rtl/nand_seq_ctrl.sv
// Multi-cycle controller that time-shares one WIDTH-bit NAND unit to evaluate all
// two-input logic functions, with valid/ready handshakes and a saturating NAND counter.
module nand_seq_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] y_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] nand_cnt_o
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
   typedef enum logic [2:0] {SrcA, SrcB, SrcT1, SrcT2, SrcT3} src_e;
   typedef enum logic [1:0] {DstT1, DstT2, DstT3, DstY} dst_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d, y_q, y_d;
   logic [2:0]       op_q, op_d, step_q, step_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   src_e             src_x, src_y;
   dst_e             dst;
   logic             last;
   logic [WIDTH-1:0] opnd_x, opnd_y, nand_res;

   // Microprogram ROM: (op, step) -> NAND sources, destination, last-step flag.
   always_comb begin
      src_x = SrcA;
      src_y = SrcA;
      dst   = DstY;
      last  = 1'b1;
      unique case (op_q)
         3'd0: src_y = SrcB;
         3'd1: begin
            if (step_q == 3'd0) begin
               src_y = SrcB; dst = DstT1; last = 1'b0;
            end else begin
               src_x = SrcT1; src_y = SrcT1;
            end
         end
         3'd2, 3'd3: begin
            case (step_q)
               3'd0: begin dst = DstT1; last = 1'b0; end
               3'd1: begin src_x = SrcB; src_y = SrcB; dst = DstT2; last = 1'b0; end
               3'd2: begin
                  src_x = SrcT1; src_y = SrcT2;
                  if (op_q == 3'd3) begin
                     dst = DstT3; last = 1'b0;
                  end
               end
               default: begin src_x = SrcT3; src_y = SrcT3; end
            endcase
         end
         3'd4, 3'd5: begin
            case (step_q)
               3'd0: begin src_y = SrcB; dst = DstT1; last = 1'b0; end
               3'd1: begin src_y = SrcT1; dst = DstT2; last = 1'b0; end
               3'd2: begin src_x = SrcB; src_y = SrcT1; dst = DstT3; last = 1'b0; end
               3'd3: begin
                  src_x = SrcT2; src_y = SrcT3;
                  if (op_q == 3'd5) begin
                     dst = DstT1; last = 1'b0;
                  end
               end
               default: begin src_x = SrcT1; src_y = SrcT1; end
            endcase
         end
         3'd6: ;
         default: begin
            if (step_q == 3'd0) begin
               dst = DstT1; last = 1'b0;
            end else begin
               src_x = SrcT1; src_y = SrcT1;
            end
         end
      endcase
   end

   always_comb begin
      opnd_x = a_q;
      unique case (src_x)
         SrcB:    opnd_x = b_q;
         SrcT1:   opnd_x = t1_q;
         SrcT2:   opnd_x = t2_q;
         SrcT3:   opnd_x = t3_q;
         default: opnd_x = a_q;
      endcase
   end

   always_comb begin
      opnd_y = a_q;
      unique case (src_y)
         SrcB:    opnd_y = b_q;
         SrcT1:   opnd_y = t1_q;
         SrcT2:   opnd_y = t2_q;
         SrcT3:   opnd_y = t3_q;
         default: opnd_y = a_q;
      endcase
   end

   assign nand_res = ~(opnd_x & opnd_y);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      step_d  = step_q;
      t1_d    = t1_q;
      t2_d    = t2_q;
      t3_d    = t3_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid_i) begin
               a_d     = a_i;
               b_d     = b_i;
               op_d    = op_i;
               step_d  = 3'd0;
               state_d = StRun;
            end
         end
         StRun: begin
            unique case (dst)
               DstT1:   t1_d = nand_res;
               DstT2:   t2_d = nand_res;
               DstT3:   t3_d = nand_res;
               default: y_d  = nand_res;
            endcase
            if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            step_d = step_q + 3'd1;
            if (last) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (out_ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         step_q  <= '0;
         t1_q    <= '0;
         t2_q    <= '0;
         t3_q    <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         step_q  <= step_d;
         t1_q    <= t1_d;
         t2_q    <= t2_d;
         t3_q    <= t3_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
      end
   end

   assign in_ready_o  = (state_q == StIdle);
   assign busy_o      = (state_q != StIdle);
   assign out_valid_o = (state_q == StDone);
   assign y_o         = y_q;
   assign nand_cnt_o  = cnt_q;

endmodule

// File: tb/tb_nand_seq_ctrl.sv
// Self-checking bench for nand_seq_ctrl: directed scenarios plus randomized ops checked
// against a plain-logic reference; a second instance with a 4-bit counter covers saturation.
module tb_nand_seq_ctrl;

   logic        clk, rst_n, in_valid, out_ready;
   logic [2:0]  op;
   logic [7:0]  a, b;
   logic        in_ready, out_valid, busy;
   logic [7:0]  y;
   logic [15:0] nand_cnt;
   logic        s_in_ready, s_out_valid, s_busy;
   logic [7:0]  s_y;
   logic [3:0]  s_nand_cnt;

   int errors = 0;
   int checks = 0;
   int model_cnt = 0;

   nand_seq_ctrl #(.WIDTH(8), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready), .op_i(op),
      .a_i(a), .b_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready), .y_o(y),
      .busy_o(busy), .nand_cnt_o(nand_cnt)
   );

   nand_seq_ctrl #(.WIDTH(8), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(s_in_ready), .op_i(op),
      .a_i(a), .b_i(b), .out_valid_o(s_out_valid), .out_ready_i(out_ready), .y_o(s_y),
      .busy_o(s_busy), .nand_cnt_o(s_nand_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ref_y(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
      case (o)
         3'd0: return ~(x & z);
         3'd1: return x & z;
         3'd2: return x | z;
         3'd3: return ~(x | z);
         3'd4: return x ^ z;
         3'd5: return ~(x ^ z);
         3'd6: return ~x;
         default: return x;
      endcase
   endfunction

   function automatic int ref_steps(input logic [2:0] o);
      case (o)
         3'd0, 3'd6: return 1;
         3'd1, 3'd7: return 2;
         3'd2:       return 3;
         3'd3, 3'd4: return 4;
         default:    return 5;
      endcase
   endfunction

   // Drives one request from an idle negedge and completes it; leaves the bench at a negedge.
   task automatic run_op(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                         input int hold, output logic [7:0] yv, output logic [7:0] syv,
                         output int lat, output bit to);
      op = o; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      lat = 0; to = 1'b1;
      while (lat <= 12) begin
         if (out_valid) begin
            to = 1'b0;
            break;
         end
         in_valid = 1'($urandom_range(0, 1));
         @(posedge clk); @(negedge clk);
         lat++;
      end
      yv = y; syv = s_y;
      repeat (hold) begin
         in_valid = 1'($urandom_range(0, 1));
         @(posedge clk); @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) begin
         in_valid = 1'($urandom); out_ready = 1'($urandom);
         op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
         @(negedge clk);
         checks++;
         if ({in_ready, out_valid, busy, y, nand_cnt} !== {3'b100, 8'h00, 16'h0000}) begin
            errors++;
            $display("FAIL reset_hold: got rdy=%b vld=%b busy=%b y=%h cnt=%h want 1 0 0 00 0000",
                     in_ready, out_valid, busy, y, nand_cnt);
         end
      end
      rst_n = 1'b1; in_valid = 1'b0;
      repeat (4) begin
         out_ready = 1'($urandom); op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
         @(negedge clk);
         checks++;
         if ({in_ready, out_valid, busy, y, nand_cnt} !== {3'b100, 8'h00, 16'h0000}) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b vld=%b busy=%b y=%h cnt=%h want 1 0 0 00 0000",
                     in_ready, out_valid, busy, y, nand_cnt);
         end
      end
      out_ready = 1'b0;
      model_cnt = 0;
   endtask

   task automatic test_sweep();
      logic [7:0] exp_y [8] = '{8'h3F, 8'hC0, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
      int         exp_l [8] = '{1, 2, 3, 4, 4, 5, 1, 2};
      logic [7:0] yv, syv;
      int         lat;
      bit         to;
      for (int i = 0; i < 8; i++) begin
         run_op(3'(i), 8'hF0, 8'hCC, 0, yv, syv, lat, to);
         model_cnt += exp_l[i];
         checks++;
         if (to) begin
            errors++;
            $display("FAIL sweep_timeout op%0d: got no out_valid want out_valid", i);
         end
         checks++;
         if (lat != exp_l[i]) begin
            errors++;
            $display("FAIL sweep_latency op%0d: got %0d want %0d", i, lat, exp_l[i]);
         end
         checks++;
         if (yv !== exp_y[i]) begin
            errors++;
            $display("FAIL sweep_y op%0d: got %h want %h", i, yv, exp_y[i]);
         end
      end
      checks++;
      if (nand_cnt !== 16'd22) begin
         errors++;
         $display("FAIL sweep_cnt: got %0d want 22", nand_cnt);
      end
   endtask

   task automatic test_backpressure();
      op = 3'd4; a = 8'hC3; b = 8'hA5; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 10 && !out_valid; i++) begin
         @(posedge clk); @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_timeout: got out_valid=%b want 1", out_valid);
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({out_valid, in_ready, y} !== {2'b10, 8'h66}) begin
            errors++;
            $display("FAIL bp_hold cyc%0d: got vld=%b rdy=%b y=%h want 1 0 66",
                     i, out_valid, in_ready, y);
         end
         in_valid = (i == 2);
         if (i == 2) begin
            op = 3'd0; a = 8'hFF; b = 8'h00;
         end
         @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready = 1'b0;
      model_cnt += 4;
      checks++;
      if ({out_valid, in_ready, nand_cnt} !== {2'b01, 16'(model_cnt)}) begin
         errors++;
         $display("FAIL bp_release: got vld=%b rdy=%b cnt=%0d want 0 1 %0d",
                  out_valid, in_ready, nand_cnt, model_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q[$];
      logic [7:0] exp_v;
      int         acc = 0, done = 0, edge_n = 0, last_edge = 0;
      bit         acc_now;
      op = 3'd1; a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 30 && done < 3; c++) begin
         acc_now = 1'b0;
         if (in_ready && in_valid) begin
            exp_q.push_back(a & b);
            if (acc > 0) begin
               checks++;
               if (edge_n - last_edge != 4) begin
                  errors++;
                  $display("FAIL b2b_gap: got %0d want 4", edge_n - last_edge);
               end
            end
            last_edge = edge_n;
            acc++;
            acc_now = 1'b1;
         end
         if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL b2b_spurious: got extra result %h want none", y);
            end else begin
               exp_v = exp_q.pop_front();
               if (y !== exp_v) begin
                  errors++;
                  $display("FAIL b2b_y: got %h want %h", y, exp_v);
               end
            end
            done++;
         end
         @(posedge clk); edge_n++; @(negedge clk);
         if (acc_now) begin
            if (acc == 3) in_valid = 1'b0;
            else begin
               a = 8'($urandom); b = 8'($urandom);
            end
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      model_cnt += 6;
      checks++;
      if (acc != 3 || done != 3 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_count: got acc=%0d done=%0d pending=%0d want 3 3 0",
                  acc, done, exp_q.size());
      end
      checks++;
      if (nand_cnt !== 16'(model_cnt)) begin
         errors++;
         $display("FAIL b2b_cnt: got %0d want %0d", nand_cnt, model_cnt);
      end
   endtask

   task automatic test_random();
      logic [2:0] o;
      logic [7:0] av, bv, yv, syv;
      int         lat;
      bit         to;
      for (int i = 0; i < 25; i++) begin
         o = 3'($urandom); av = 8'($urandom); bv = 8'($urandom);
         run_op(o, av, bv, $urandom_range(0, 3), yv, syv, lat, to);
         model_cnt += ref_steps(o);
         checks++;
         if (to || lat != ref_steps(o) || yv !== ref_y(o, av, bv)) begin
            errors++;
            $display("FAIL rand op%0d a=%h b=%h: got y=%h lat=%0d to=%b want y=%h lat=%0d",
                     o, av, bv, yv, lat, to, ref_y(o, av, bv), ref_steps(o));
         end
         checks++;
         if (nand_cnt !== 16'(model_cnt)) begin
            errors++;
            $display("FAIL rand_cnt: got %0d want %0d", nand_cnt, model_cnt);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] yv, syv;
      int         lat;
      bit         to;
      op = 3'd5; a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL midrst_busy: got %b want 1", busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, busy, y, nand_cnt} !== {3'b100, 8'h00, 16'h0000}) begin
         errors++;
         $display("FAIL midrst_state: got rdy=%b vld=%b busy=%b y=%h cnt=%h want 1 0 0 00 0000",
                  in_ready, out_valid, busy, y, nand_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_cnt = 0;
      run_op(3'd0, 8'hFF, 8'h0F, 0, yv, syv, lat, to);
      model_cnt = 1;
      checks++;
      if (to || yv !== 8'hF0 || nand_cnt !== 16'd1) begin
         errors++;
         $display("FAIL midrst_after: got y=%h cnt=%0d to=%b want F0 1 0", yv, nand_cnt, to);
      end
   endtask

   task automatic test_saturation();
      logic [7:0] av, bv, yv, syv;
      int         lat, sat_exp;
      bit         to;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      model_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         av = 8'($urandom); bv = 8'($urandom);
         run_op(3'd5, av, bv, 0, yv, syv, lat, to);
         model_cnt += 5;
         sat_exp = (model_cnt > 15) ? 15 : model_cnt;
         checks++;
         if (to || syv !== ref_y(3'd5, av, bv)) begin
            errors++;
            $display("FAIL sat_y: got %h to=%b want %h", syv, to, ref_y(3'd5, av, bv));
         end
         checks++;
         if (s_nand_cnt !== 4'(sat_exp) || nand_cnt !== 16'(model_cnt)) begin
            errors++;
            $display("FAIL sat_cnt: got %0d/%0d want %0d/%0d",
                     s_nand_cnt, nand_cnt, sat_exp, model_cnt);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      @(negedge clk);
      test_reset();
      test_sweep();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_mid_reset();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nand_seq_ctrl.md
# nand_seq_ctrl

Multi-cycle controller that time-shares a single WIDTH-bit bitwise NAND unit to evaluate the full set of two-input logic functions. It accepts one operation at a time over a valid/ready input handshake and sequences 1–5 NAND evaluations through a small temporary register set. It then presents the result over a valid/ready output handshake. It sits between the lab's operand/op source and the universal-gate datapath, and also counts NAND evaluations for characterisation.

## Interface
- WIDTH, 8, operand/result width in bits; the NAND unit is WIDTH bits, bitwise.
- CNT_W, 16, width of the saturating NAND-evaluation counter.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and op are presented.
- in_ready  output  1  block can accept a request.
- op  input  3  function select.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result y is valid.
- out_ready  input  1  consumer accepts y.
- y  output  WIDTH  result.
- busy  output  1  state is not IDLE.
- nand_cnt  output  CNT_W  total NAND evaluations since reset; saturating.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: one NAND step per cycle.
  - DONE: out_valid=1.
- Request acceptance:
  - A request is accepted on a rising edge with state=IDLE and in_valid=1.
  - On acceptance, a, b and op are captured into internal regs A, B and OP, the step counter is cleared, and the state goes to RUN.
- NAND step behaviour:
  - Each RUN cycle drives the NAND unit with two sources selected from {A, B, T1, T2, T3}, per the microprogram below.
  - On the edge, the NAND result is written to the listed destination, and nand_cnt increments by 1, saturating at 2^CNT_W-1.
  - The last step writes y and moves the state to DONE.
- Microprogram (n(x,y) = ~(x&y)):
  - op0 NAND: y=n(A,B). 1 step.
  - op1 AND: T1=n(A,B); y=n(T1,T1). 2 steps.
  - op2 OR: T1=n(A,A); T2=n(B,B); y=n(T1,T2). 3 steps.
  - op3 NOR: the three OR steps, writing T3 instead of y; then y=n(T3,T3). 4 steps.
  - op4 XOR: T1=n(A,B); T2=n(A,T1); T3=n(B,T1); y=n(T2,T3). 4 steps.
  - op5 XNOR: the four XOR steps, writing T1 on the last step; then y=n(T1,T1). 5 steps.
  - op6 NOT A: y=n(A,A). 1 step.
  - op7 BUF A: T1=n(A,A); y=n(T1,T1). 2 steps.
- DONE handshake:
  - y and out_valid are held stable until out_ready=1 on an edge; that edge returns the state to IDLE.
  - A new request cannot be accepted on that same edge; in_ready is 0 in DONE.
- Ignored inputs:
  - in_valid outside IDLE is ignored.
  - Changes on a, b or op after acceptance have no effect.
- Reset:
  - Asserting rst_n low at any time, including mid-RUN, immediately aborts the operation.
  - All state is cleared, and no partial result is ever presented.

## Timing
- Reset values:
  - in_ready=1, busy=0, out_valid=0.
  - y=0, nand_cnt=0.
  - T1/T2/T3/A/B/OP=0; state=IDLE.
- Latency: request accepted at edge k → out_valid=1 after edge k+N, where N is the op's step count (1..5).
- Throughput (out_ready held 1):
  - One op per N+2 cycles: acceptance, N steps, then the DONE handshake edge.
  - The next acceptance occurs on the edge after the return to IDLE.
- busy=1 from the acceptance edge until the out handshake edge.
- nand_cnt:
  - Updates only on RUN edges.
  - Never increments in IDLE or DONE, nor on steps aborted by reset.
- All outputs are registered or decoded from the state register only; there is no combinational path from in_valid or out_ready to any output.

## Test plan
- Reset: hold rst_n=0 with random inputs → in_ready=1, out_valid=0, busy=0, y=0, nand_cnt=0. Then release rst_n and check that all outputs hold these values until in_valid.
- Function sweep, WIDTH=8, a=0xF0, b=0xCC, ops 0..7 in turn → y = 0x3F, 0xC0, 0xFC, 0x03, 0x3C, 0xC3, 0x0F, 0xF0 respectively. Check that out_valid rises exactly 1, 2, 3, 4, 4, 5, 1, 2 cycles after acceptance, and that final nand_cnt=22.
- Backpressure: XOR with a=0xC3, b=0xA5 and out_ready=0 for 6 cycles after out_valid → y=0x66 held stable, in_ready=0, and a pulsed in_valid with different operands is ignored. With out_ready=1, out_valid falls after that edge, and in_ready=1 the cycle after.
- Back-to-back: in_valid and out_ready held 1, three AND ops → each completes in 4 cycles edge-to-edge, with no request lost or duplicated.
- Reset mid-RUN: start XNOR, drop rst_n at step 3 → outputs return to reset values immediately and nand_cnt=0. After release, a NAND op with a=0xFF, b=0x0F gives y=0xF0 and nand_cnt=1.
- Saturation: CNT_W=4, issue 4 XNOR ops (20 steps) → nand_cnt reaches 15 and stays there, while results remain correct.
